nearest_neighbor_read_sched: RTL



---
 rtl/up_sample_sched_pkg.sv | 16 +
 rtl/sched_dim_counter.sv | 29 ++
 rtl/nearest_neighbor_read_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/up_sample_sched_pkg.sv
// Shared widths and state encoding for the up_sample iteration-domain schedulers.
package up_sample_sched_pkg;

  localparam int CTRL_W   = 16;
  localparam int NUM_DIMS = 3;

  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RUN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/sched_dim_counter.sv
// One loop dimension: wrap-around counter over 0..extent-1, wrap flags the carry out.
module sched_dim_counter
  import up_sample_sched_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  inc,
  input  ctrl_t extent,
  output ctrl_t value,
  output logic  wrap
);

  // An extent of 1 makes every increment a wrap, so the dimension holds at 0.
  assign wrap = inc && (value == extent - ctrl_t'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr || wrap) begin
      value <= '0;
    end else if (inc) begin
      value <= value + ctrl_t'(1);
    end
  end

endmodule

// File: rtl/nearest_neighbor_read_sched.sv
// Nearest-neighbour read scheduler: walks the EXTENT_0 x EXTENT_1 x EXTENT_2 domain
// row-major, one iteration every II cycles. Optional stall port: NN_READ_SCHED_STALL_EN.
module nearest_neighbor_read_sched
  import up_sample_sched_pkg::*;
#(
  parameter int unsigned EXTENT_0    = 1,
  parameter int unsigned EXTENT_1    = 128,
  parameter int unsigned EXTENT_2    = 128,
  parameter int unsigned START_DELAY = 0,
  parameter int unsigned II          = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             start,
`ifdef NN_READ_SCHED_STALL_EN
  input  logic                             stall,
`endif
  output logic                             op_hcompute_nearest_neighbor_stencil_read_ren,
  output logic [NUM_DIMS-1:0][CTRL_W-1:0]  op_hcompute_nearest_neighbor_stencil_read_ctrl_vars,
  output logic                             busy,
  output logic                             done
);

  localparam ctrl_t DELAY_LOAD = (START_DELAY > 0) ? ctrl_t'(START_DELAY - 1) : '0;
  localparam ctrl_t II_LAST    = ctrl_t'(II - 1);
  localparam logic [NUM_DIMS-1:0][CTRL_W-1:0] EXTENT =
    {ctrl_t'(EXTENT_2), ctrl_t'(EXTENT_1), ctrl_t'(EXTENT_0)};

  sched_state_t        state, state_next;
  ctrl_t               delay_cnt, delay_next;
  ctrl_t               ii_cnt, ii_next;
  logic                ren_q;
  logic                stall_eff;
  logic                fire;
  logic [NUM_DIMS-1:0] inc;
  logic [NUM_DIMS-1:0] wrap;

`ifdef NN_READ_SCHED_STALL_EN
  assign stall_eff = stall;
`else
  assign stall_eff = 1'b0;
`endif

  // ren_q is only ever set in RUN, so stall needs no state qualification here.
  assign fire = ren_q & ~stall_eff;
  assign op_hcompute_nearest_neighbor_stencil_read_ren = fire;

  // Innermost dimension counts iterations; each outer one counts inner wraps.
  assign inc[NUM_DIMS-1] = fire;
  for (genvar k = 0; k < NUM_DIMS - 1; k++) begin : g_carry
    assign inc[k] = wrap[k+1];
  end

  for (genvar k = 0; k < NUM_DIMS; k++) begin : g_dim
    sched_dim_counter u_dim (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (flush),
      .inc    (inc[k]),
      .extent (EXTENT[k]),
      .value  (op_hcompute_nearest_neighbor_stencil_read_ctrl_vars[k]),
      .wrap   (wrap[k])
    );
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    delay_next = delay_cnt;
    ii_next    = ii_cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = (START_DELAY == 0) ? RUN : DELAY;
          delay_next = DELAY_LOAD;
          ii_next    = '0;
        end
      end
      DELAY: begin
        if (delay_cnt == '0) begin
          state_next = RUN;
        end else begin
          delay_next = delay_cnt - ctrl_t'(1);
        end
      end
      RUN: begin
        if (!stall_eff) begin
          ii_next = (ii_cnt == II_LAST) ? '0 : ii_cnt + ctrl_t'(1);
          // Outermost wrap means the final iteration was just issued.
          if (wrap[0]) begin
            state_next = DONE;
            ii_next    = '0;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (flush) begin
      state_next = IDLE;
      delay_next = '0;
      ii_next    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      delay_cnt <= '0;
      ii_cnt    <= '0;
      ren_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      delay_cnt <= delay_next;
      ii_cnt    <= ii_next;
      ren_q     <= (state_next == RUN) && (ii_next == '0);
      busy      <= (state_next == DELAY) || (state_next == RUN);
      done      <= (state_next == DONE);
    end
  end

endmodule
